// File: rtl/pwm_duty_meter_if.sv
// Valid/ready sample port of the PWM duty meter.
// DATA_W is CHANNELS*CNT_W of the attached meter.
interface pwm_duty_meter_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/pwm_duty_meter.sv
// Multi-channel PWM duty meter: per-window high counts over valid/ready.
// Optional PWM_DUTY_METER_SYNC_EN adds a 2-flop input synchronizer.
module pwm_duty_meter #(
  parameter int CHANNELS = 1,
  parameter int WINDOW   = 2500,
  parameter int CNT_W    = $clog2(WINDOW + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CHANNELS-1:0] pwm_in,
  pwm_duty_meter_if.master    smp,
  output logic                overrun,
  input  logic                overrun_clear
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);

  if (WINDOW < 2) begin : g_bad_window
    $error("pwm_duty_meter: WINDOW must be at least 2");
  end
  if ((1 << CNT_W) <= WINDOW) begin : g_bad_cnt_w
    $error("pwm_duty_meter: CNT_W cannot hold WINDOW");
  end

  logic [CHANNELS-1:0] pwm_s;

`ifdef PWM_DUTY_METER_SYNC_EN
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

  assign pwm_s = sync2_q;
`else
  assign pwm_s = pwm_in;
`endif

  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_d;

  logic [CHANNELS-1:0][CNT_W-1:0] acc_q;
  logic [CHANNELS-1:0][CNT_W-1:0] acc_d;
  logic [CHANNELS-1:0][CNT_W-1:0] data_q;
  logic [CHANNELS-1:0][CNT_W-1:0] data_d;
  logic [CHANNELS-1:0][CNT_W-1:0] sum;

  logic valid_q;
  logic valid_d;
  logic ovr_q;
  logic ovr_d;

  logic last;
  logic run;
  logic xfer;
  logic ovr_set;

  assign last    = enable && (win_q == LAST);
  assign run     = enable && !last;
  assign xfer    = valid_q && smp.sample_ready;
  assign ovr_set = last && valid_q && !smp.sample_ready;

  // The final window cycle's bit is folded into the stored sample.
  always_comb begin
    sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum[c] = acc_q[c] + CNT_W'(pwm_s[c]);
    end
  end

  always_comb begin
    win_d  = '0;
    acc_d  = '0;
    data_d = data_q;
    if (run) begin
      win_d = win_q + WIN_W'(1);
      acc_d = sum;
    end
    if (last) begin
      data_d = sum;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (last) begin
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // Set dominates a simultaneous clear.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (overrun_clear) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      win_q   <= win_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign smp.sample_data  = data_q;
  assign smp.sample_valid = valid_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter (CHANNELS=2, WINDOW=8).
// Window-queue reference model plus table and corner sequences.
module tb_pwm_duty_meter;

  localparam int CH = 2;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          enable;
  logic          ovc;
  logic          overrun;
  logic [CH-1:0] pwm;

  pwm_duty_meter_if #(.DATA_W(CH * CW)) sif ();

  pwm_duty_meter #(
    .CHANNELS (CH),
    .WINDOW   (W),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .pwm_in        (pwm),
    .smp           (sif.master),
    .overrun       (overrun),
    .overrun_clear (ovc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [CH-1:0] hist[$];
  int            m_data[CH];
  logic          m_valid;
  logic          m_ovr;
  logic [CH-1:0] s1;
  logic [CH-1:0] s2;

  typedef struct {
    logic [7:0] p0;
    logic [7:0] p1;
    int         e0;
    int         e1;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dat(input int c);
    logic [CH*CW-1:0] v;
    v = sif.sample_data;
    return 32'(v[c*CW +: CW]);
  endfunction

  task automatic model_step();
    logic [CH-1:0] p;
    logic          wend;
    logic          xfer;
    if (rst) begin
      hist.delete();
      foreach (m_data[c]) m_data[c] = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      s1      = '0;
      s2      = '0;
    end else begin
`ifdef PWM_DUTY_METER_SYNC_EN
      p  = s2;
      s2 = s1;
      s1 = pwm;
`else
      p = pwm;
`endif
      xfer = m_valid && sif.sample_ready;
      wend = 1'b0;
      if (!enable) begin
        hist.delete();
      end else begin
        hist.push_back(p);
        wend = (hist.size() == W);
      end
      if (wend) begin
        foreach (m_data[c]) begin
          m_data[c] = 0;
          foreach (hist[i]) m_data[c] += int'(hist[i][c]);
        end
        hist.delete();
      end
      if (wend && m_valid && !sif.sample_ready) m_ovr = 1'b1;
      else if (ovc) m_ovr = 1'b0;
      if (wend) m_valid = 1'b1;
      else if (xfer) m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_valid", 32'(sif.sample_valid), 32'(m_valid));
    chk("model_overrun", 32'(overrun), 32'(m_ovr));
    chk("model_ch0", dat(0), 32'(m_data[0]));
    chk("model_ch1", dat(1), 32'(m_data[1]));
  endtask

  task automatic win(input logic [7:0] p0,
                     input logic [7:0] p1,
                     input logic [7:0] rm,
                     input logic [7:0] cm);
    for (int i = 0; i < W; i++) begin
      pwm              = {p1[i], p0[i]};
      sif.sample_ready = rm[i];
      ovc              = cm[i];
      tick();
    end
    ovc = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'hFF, 8'h00, 8, 0};
    tbl[1] = '{8'h33, 8'h80, 4, 1};
    tbl[2] = '{8'h01, 8'hFE, 1, 7};
    tbl[3] = '{8'hAA, 8'h55, 4, 4};
    tbl[4] = '{8'h00, 8'h7F, 0, 7};

    rst = 1'b1;
    enable = 1'b0;
    pwm = '0;
    ovc = 1'b0;
    sif.sample_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(sif.sample_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_data", 32'(sif.sample_data), 0);

    rst = 1'b0;
    enable = 1'b1;
    foreach (tbl[k]) begin
      win(tbl[k].p0, tbl[k].p1, 8'hFF, 8'h00);
      chk("tbl_valid", 32'(sif.sample_valid), 1);
      chk("tbl_ch0", dat(0), 32'(tbl[k].e0));
      chk("tbl_ch1", dat(1), 32'(tbl[k].e1));
      chk("tbl_overrun", 32'(overrun), 0);
    end

    win(8'h03, 8'h00, 8'h00, 8'h00);
    win(8'h1F, 8'h00, 8'h00, 8'h00);
    win(8'h7F, 8'h00, 8'h00, 8'h00);
    chk("bp_valid", 32'(sif.sample_valid), 1);
    chk("bp_ch0", dat(0), 7);
    chk("bp_overrun", 32'(overrun), 1);

    pwm = '0;
    sif.sample_ready = 1'b1;
    tick();
    chk("accept_drop", 32'(sif.sample_valid), 0);
    sif.sample_ready = 1'b0;
    ovc = 1'b1;
    tick();
    ovc = 1'b0;
    chk("clear_overrun", 32'(overrun), 0);
    for (int i = 0; i < W - 2; i++) tick();
    chk("new_valid", 32'(sif.sample_valid), 1);
    chk("no_overrun", 32'(overrun), 0);

    win(8'hFF, 8'h00, 8'h80, 8'h00);
    chk("simul_valid", 32'(sif.sample_valid), 1);
    chk("simul_ch0", dat(0), 8);
    chk("simul_overrun", 32'(overrun), 0);

    win(8'h0F, 8'h00, 8'h00, 8'h80);
    chk("setwins_overrun", 32'(overrun), 1);
    chk("setwins_ch0", dat(0), 4);

    win(8'h00, 8'h00, 8'hFF, 8'h01);
    chk("drain_overrun", 32'(overrun), 0);

    pwm = 2'b11;
    sif.sample_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("gate_idle_valid", 32'(sif.sample_valid), 0);
    enable = 1'b1;
    for (int i = 0; i < W - 1; i++) tick();
    chk("gate_early_valid", 32'(sif.sample_valid), 0);
    tick();
    chk("gate_valid", 32'(sif.sample_valid), 1);
    chk("gate_ch0", dat(0), 8);
    chk("gate_ch1", dat(1), 8);

    win(8'hFF, 8'hFF, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_valid", 32'(sif.sample_valid), 1);
    chk("pre_rst_overrun", 32'(overrun), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(sif.sample_valid), 0);
    chk("midrst_data", 32'(sif.sample_data), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    win(8'h0F, 8'hF0, 8'hFF, 8'h00);
    chk("postrst_valid", 32'(sif.sample_valid), 1);
    chk("postrst_ch0", dat(0), 4);
    chk("postrst_ch1", dat(1), 4);

    for (int i = 0; i < 600; i++) begin
      rst              = ($urandom_range(0, 149) == 0);
      enable           = ($urandom_range(0, 19) != 0);
      pwm              = CH'($urandom);
      sif.sample_ready = ($urandom_range(0, 2) == 0);
      ovc              = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
